// File: rtl/fp_normalizer_pkg.sv
// Shared single-precision FP definitions used by the adder back end.
// Holds the default field widths, the exponent bias, the all-ones exponent
// constant, the normalizer state encoding and the result record that the
// normalizer produces and the rounding stage consumes.
package fp_normalizer_pkg;

    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;
    localparam int BIAS      = 127;

    localparam logic [EXP_W_DEF-1:0] EXP_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } normState_e;

    typedef struct packed {
        logic                 sign;
        logic [EXP_W_DEF-1:0] exp;
        logic [MAN_W_DEF-1:0] frac;
        logic                 zero;
        logic                 ovf;
        logic                 unf;
    } fpResult_t;

endpackage

// File: rtl/fp_normalizer_norm_step.sv
// fp_norm_step: one normalization evaluation, purely combinational.
// Ports:
//   exp_i       working exponent
//   mant_i      working sum (carry, hidden, fraction)
//   nextExp_o   exponent after this step
//   nextMant_o  sum after this step
//   done_o      result is final after this step
//   zero_o      result is zero
//   ovf_o       exponent reached all-ones (infinity)
//   unf_o       exponent exhausted before normalization (flush to zero)
module fp_norm_step #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W-1:0]   exp_i,
    input  logic [MAN_W+1:0]   mant_i,
    output logic [EXP_W-1:0]   nextExp_o,
    output logic [MAN_W+1:0]   nextMant_o,
    output logic               done_o,
    output logic               zero_o,
    output logic               ovf_o,
    output logic               unf_o
);

    logic [EXP_W-1:0] expInc;

    assign expInc = exp_i + EXP_W'(1);

    // Rules are tried in priority order; only the left-shift rule keeps the
    // block iterating, every other rule finishes the operation.
    always_comb begin
        nextExp_o  = exp_i;
        nextMant_o = mant_i;
        done_o     = 1'b0;
        zero_o     = 1'b0;
        ovf_o      = 1'b0;
        unf_o      = 1'b0;
        if (mant_i == '0) begin
            zero_o     = 1'b1;
            done_o     = 1'b1;
            nextExp_o  = '0;
            nextMant_o = '0;
        end else if (mant_i[MAN_W+1]) begin
            // The bit shifted out here is truncated; rounding happens later.
            done_o     = 1'b1;
            nextExp_o  = expInc;
            nextMant_o = mant_i >> 1;
            if (expInc == {EXP_W{1'b1}}) begin
                ovf_o      = 1'b1;
                nextMant_o = '0;
            end
        end else if (mant_i[MAN_W]) begin
            done_o = 1'b1;
        end else if (exp_i <= EXP_W'(1)) begin
            unf_o      = 1'b1;
            done_o     = 1'b1;
            nextExp_o  = '0;
            nextMant_o = '0;
        end else begin
            nextExp_o  = exp_i - EXP_W'(1);
            nextMant_o = mant_i << 1;
        end
    end

endmodule

// File: rtl/fp_normalizer.sv
// fp_normalizer: iterative post-addition normalizer, one shift per cycle.
// Ports:
//   CLK, RST            rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only when idle)
//   in_sign/exp/mant    sign, selected exponent and raw sum from the adder
//   out_valid/out_ready result handshake; result held until accepted
//   out_sign/exp/frac   normalized result, hidden bit dropped
//   out_zero/ovf/unf    mutually exclusive result flags
module fp_normalizer
    import fp_normalizer_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W+1:0] in_mant,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_frac,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_unf
);

    normState_e       state_q, state_d;
    logic             inReady_q, inReady_d;
    logic             outValid_q, outValid_d;
    logic             sign_q, sign_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [MAN_W+1:0] mant_q, mant_d;
    logic             outSign_q, outSign_d;
    logic [EXP_W-1:0] outExp_q, outExp_d;
    logic [MAN_W-1:0] outFrac_q, outFrac_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [EXP_W-1:0] stepExp;
    logic [MAN_W+1:0] stepMant;
    logic             stepDone;
    logic             stepZero;
    logic             stepOvf;
    logic             stepUnf;

    fp_norm_step #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_step (
        .exp_i      (exp_q),
        .mant_i     (mant_q),
        .nextExp_o  (stepExp),
        .nextMant_o (stepMant),
        .done_o     (stepDone),
        .zero_o     (stepZero),
        .ovf_o      (stepOvf),
        .unf_o      (stepUnf)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            outSign_q  <= 1'b0;
            outExp_q   <= '0;
            outFrac_q  <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inReady_q  <= inReady_d;
            outValid_q <= outValid_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mant_q     <= mant_d;
            outSign_q  <= outSign_d;
            outExp_q   <= outExp_d;
            outFrac_q  <= outFrac_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // The handshake flags are computed one cycle ahead so that in_ready and
    // out_valid come straight from flops; result registers only change on
    // the cycle normalization finishes, so they hold through backpressure.
    always_comb begin
        state_d    = state_q;
        inReady_d  = inReady_q;
        outValid_d = outValid_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mant_d     = mant_q;
        outSign_d  = outSign_q;
        outExp_d   = outExp_q;
        outFrac_d  = outFrac_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d    = in_sign;
                    exp_d     = in_exp;
                    mant_d    = in_mant;
                    inReady_d = 1'b0;
                    state_d   = NORM;
                end
            end
            NORM: begin
                exp_d  = stepExp;
                mant_d = stepMant;
                if (stepDone) begin
                    outSign_d  = sign_q;
                    outExp_d   = stepExp;
                    outFrac_d  = stepMant[MAN_W-1:0];
                    zero_d     = stepZero;
                    ovf_d      = stepOvf;
                    unf_d      = stepUnf;
                    outValid_d = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    inReady_d  = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                inReady_d  = 1'b1;
                outValid_d = 1'b0;
            end
        endcase
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out_sign  = outSign_q;
    assign out_exp   = outExp_q;
    assign out_frac  = outFrac_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

endmodule

// File: tb/tb_fp_normalizer.sv
// Directed testbench for fp_normalizer with hand-computed expected results.
module tb_fp_normalizer;

    logic        CLK;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_zero;
    logic        out_ovf;
    logic        out_unf;

    int checks;
    int failures;
    int latency;

    fp_normalizer dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_frac  (out_frac),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one operand for a single accept edge, then counts cycles
    // (T1 is the first cycle after the accept edge) until out_valid.
    task automatic applyStimulus(input logic sign, input logic [7:0] exp,
                                 input logic [24:0] mant);
        in_valid = 1'b1;
        in_sign  = sign;
        in_exp   = exp;
        in_mant  = mant;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        in_exp   = 8'h00;
        in_mant  = '0;
        latency  = 1;
        while (!out_valid && latency < 100) begin
            @(posedge CLK);
            #1;
            latency++;
        end
    endtask

    // Runs one vector with out_ready high and checks result, latency and
    // the return to idle on the cycle after the output handshake.
    task automatic runVector(input string tag, input logic sign, input logic [7:0] exp,
                             input logic [24:0] mant, input int expLat,
                             input logic [7:0] expExp, input logic [22:0] expFrac,
                             input logic expZero, input logic expOvf, input logic expUnf);
        out_ready = 1'b1;
        applyStimulus(sign, exp, mant);
        checkOutput({tag, "_lat"},   32'(latency),  32'(expLat));
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_sign"},  32'(out_sign), 32'(sign));
        checkOutput({tag, "_exp"},   32'(out_exp),  32'(expExp));
        checkOutput({tag, "_frac"},  32'(out_frac), 32'(expFrac));
        checkOutput({tag, "_flags"}, 32'({out_zero, out_ovf, out_unf}),
                    32'({expZero, expOvf, expUnf}));
        @(posedge CLK);
        #1;
        checkOutput({tag, "_idle_rdy"}, 32'(in_ready),  32'd1);
        checkOutput({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        latency   = 0;
        RST       = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'h00;
        in_mant   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;

        checkOutput("rst_ready", 32'(in_ready),  32'd1);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_exp",   32'(out_exp),   32'd0);
        checkOutput("rst_frac",  32'(out_frac),  32'd0);
        checkOutput("rst_sign",  32'(out_sign),  32'd0);
        checkOutput("rst_flags", 32'({out_zero, out_ovf, out_unf}), 32'd0);

        runVector("hidden", 1'b0, 8'h80, 25'h0C00000, 2,  8'h80, 23'h400000, 0, 0, 0);
        runVector("carry",  1'b1, 8'h80, 25'h1800000, 2,  8'h81, 23'h400000, 0, 0, 0);
        runVector("ovf",    1'b0, 8'hFE, 25'h1000000, 2,  8'hFF, 23'h000000, 0, 1, 0);
        runVector("lsb",    1'b0, 8'h85, 25'h0000001, 25, 8'h6E, 23'h000000, 0, 0, 0);
        runVector("unf",    1'b1, 8'h03, 25'h0100000, 4,  8'h00, 23'h000000, 0, 0, 1);
        runVector("zero",   1'b1, 8'h40, 25'h0000000, 2,  8'h00, 23'h000000, 1, 0, 0);
        runVector("shift2", 1'b0, 8'h10, 25'h0280000, 4,  8'h0E, 23'h200000, 0, 0, 0);

        // Backpressure: result must hold while out_ready is low, and a
        // second operand offered while busy must be ignored.
        out_ready = 1'b0;
        applyStimulus(1'b0, 8'h80, 25'h0C00000);
        checkOutput("bp_lat", 32'(latency), 32'd2);
        in_valid = 1'b1;
        in_exp   = 8'h22;
        in_mant  = 25'h1800000;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_ready", 32'(in_ready),  32'd0);
            checkOutput("bp_exp",   32'(out_exp),   32'h80);
            checkOutput("bp_frac",  32'(out_frac),  32'h400000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("bp_release_rdy", 32'(in_ready),  32'd1);
        checkOutput("bp_release_vld", 32'(out_valid), 32'd0);

        // Reset in the middle of a long normalization.
        in_valid = 1'b1;
        in_sign  = 1'b1;
        in_exp   = 8'h85;
        in_mant  = 25'h0000001;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        checkOutput("mid_busy", 32'(in_ready), 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        checkOutput("mid_rst_ready", 32'(in_ready),  32'd1);
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_exp",   32'(out_exp),   32'd0);
        repeat (30) @(posedge CLK);
        #1;
        checkOutput("mid_rst_stays", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
